// File: rtl/ula_divisor.sv
// ula_divisor: sequential unsigned restoring divider, one quotient bit per clock.
// Start/finish handshake; results held until the next accepted start.
module ula_divisor #(
    parameter int W = 23
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         start,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_zero,
    output logic         busy,
    output logic         finish
);

    localparam int KW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ITER = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [W-1:0]  d_reg;
    logic [W-1:0]  b_reg;
    logic [W:0]    r_reg;
    logic [W-1:0]  q_reg;
    logic [KW-1:0] k;
    logic          dz;

    logic [W:0]    t;
    logic [W:0]    t_sub;
    logic          ge;

    // One restoring trial subtraction of the shifted partial remainder
    always_comb begin
        t     = {r_reg[W-1:0], d_reg[W-1]};
        t_sub = t - {1'b0, b_reg};
        ge    = (t >= {1'b0, b_reg});
    end

    // Control FSM and internal datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            d_reg <= '0;
            b_reg <= '0;
            r_reg <= '0;
            q_reg <= '0;
            k     <= '0;
            dz    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        d_reg <= a;
                        b_reg <= b;
                        r_reg <= '0;
                        q_reg <= '0;
                        k     <= '0;
                    end
                end
                LOAD: begin
                    if (b_reg == '0) begin
                        q_reg <= '1;
                        r_reg <= {1'b0, d_reg};
                        dz    <= 1'b1;
                        state <= DONE;
                    end else begin
                        dz    <= 1'b0;
                        state <= ITER;
                    end
                end
                ITER: begin
                    d_reg <= d_reg << 1;
                    r_reg <= ge ? t_sub : t;
                    q_reg <= {q_reg[W-2:0], ge};
                    k     <= k + 1'b1;
                    if (k == KW'(W - 1))
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered outputs; results publish together with the finish pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            busy      <= 1'b0;
            finish    <= 1'b0;
        end else begin
            busy   <= (state != IDLE);
            finish <= (state == DONE);
            if (state == DONE) begin
                quotient  <= q_reg;
                remainder <= r_reg[W-1:0];
                div_zero  <= dz;
            end
        end
    end

endmodule

// File: tb/tb_ula_divisor.sv
// tb_ula_divisor: self-checking bench for ula_divisor.
// Directed scenarios plus randomized back-to-back runs against an arithmetic model.
module tb_ula_divisor;

    localparam int W = 23;
    localparam int NCYC = 45;

    logic         clk;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         start;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic         busy;
    logic         finish;

    int checks;
    int errors;
    int cyc;

    ula_divisor #(.W(W)) dut (
        .clk(clk),
        .reset(reset),
        .a(a),
        .b(b),
        .start(start),
        .quotient(quotient),
        .remainder(remainder),
        .div_zero(div_zero),
        .busy(busy),
        .finish(finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count used for finish spacing
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Start one operation and observe cycles 0..NCYC-1 after the accept edge.
    // inj: cycle at which a 1/1 start is pulsed; rstc: cycle at which reset is asserted.
    task automatic do_op(
        input  logic [W-1:0]   av,
        input  logic [W-1:0]   bv,
        input  int             inj,
        input  int             rstc,
        output int             fcyc,
        output int             fcnt,
        output logic [63:0]    btrace,
        output logic [W-1:0]   q,
        output logic [W-1:0]   r,
        output logic           dz,
        output logic [2*W+2:0] snap
    );
        fcyc   = -1;
        fcnt   = 0;
        btrace = '0;
        q      = '0;
        r      = '0;
        dz     = 1'b0;
        snap   = '1;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < NCYC; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            btrace[n] = busy;
            if (finish === 1'b1) begin
                fcnt++;
                if (fcyc < 0) begin
                    fcyc = n;
                    q    = quotient;
                    r    = remainder;
                    dz   = div_zero;
                end
            end
            if (n == inj) begin
                a     = 23'd1;
                b     = 23'd1;
                start = 1'b1;
            end
            if (n == inj + 1)
                start = 1'b0;
            if (n == rstc)
                reset = 1'b0;
            if (n == rstc + 1) begin
                reset = 1'b1;
                snap  = {quotient, remainder, div_zero, busy, finish};
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({quotient, remainder, div_zero, busy, finish} !== '0) begin
            errors++;
            $display("FAIL reset_state got q=%h r=%h dz=%b busy=%b fin=%b want all 0",
                     quotient, remainder, div_zero, busy, finish);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int fc, fn;
        logic [63:0] bt, bexp;
        logic [W-1:0] q, r;
        logic dz;
        logic [2*W+2:0] sn;
        do_op(23'd100, 23'd7, -10, -10, fc, fn, bt, q, r, dz, sn);
        bexp = ((64'd1 << (W + 3)) - 64'd1) ^ 64'd1;
        checks++;
        if (fc !== W + 2 || fn !== 1) begin
            errors++;
            $display("FAIL basic_latency got cyc=%0d cnt=%0d want cyc=%0d cnt=1", fc, fn, W + 2);
        end
        checks++;
        if (bt[NCYC-1:0] !== bexp[NCYC-1:0]) begin
            errors++;
            $display("FAIL basic_busy got %h want %h", bt[NCYC-1:0], bexp[NCYC-1:0]);
        end
        checks++;
        if (q !== 23'd14 || r !== 23'd2 || dz !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got q=%0d r=%0d dz=%b want 14 2 0", q, r, dz);
        end
        checks++;
        if (quotient !== 23'd14 || remainder !== 23'd2) begin
            errors++;
            $display("FAIL basic_hold got q=%0d r=%0d want 14 2", quotient, remainder);
        end
    endtask

    task automatic test_edges;
        int fc, fn;
        logic [63:0] bt;
        logic [W-1:0] q, r;
        logic dz;
        logic [2*W+2:0] sn;
        do_op(23'd5, 23'd9, -10, -10, fc, fn, bt, q, r, dz, sn);
        checks++;
        if (fc !== W + 2 || q !== 23'd0 || r !== 23'd5 || dz !== 1'b0) begin
            errors++;
            $display("FAIL small_dividend got cyc=%0d q=%0d r=%0d dz=%b want %0d 0 5 0",
                     fc, q, r, dz, W + 2);
        end
        do_op(23'h7FFFFF, 23'd1, -10, -10, fc, fn, bt, q, r, dz, sn);
        checks++;
        if (q !== 23'h7FFFFF || r !== 23'd0 || dz !== 1'b0) begin
            errors++;
            $display("FAIL div_by_one got q=%h r=%h dz=%b want 7fffff 0 0", q, r, dz);
        end
    endtask

    task automatic test_div_zero;
        int fc, fn;
        logic [63:0] bt, bexp;
        logic [W-1:0] q, r;
        logic dz;
        logic [2*W+2:0] sn;
        do_op(23'h123456, 23'd0, -10, -10, fc, fn, bt, q, r, dz, sn);
        bexp = 64'h6;
        checks++;
        if (fc !== 2 || fn !== 1) begin
            errors++;
            $display("FAIL dz_latency got cyc=%0d cnt=%0d want 2 1", fc, fn);
        end
        checks++;
        if (bt[NCYC-1:0] !== bexp[NCYC-1:0]) begin
            errors++;
            $display("FAIL dz_busy got %h want %h", bt[NCYC-1:0], bexp[NCYC-1:0]);
        end
        checks++;
        if (q !== 23'h7FFFFF || r !== 23'h123456 || dz !== 1'b1) begin
            errors++;
            $display("FAIL dz_result got q=%h r=%h dz=%b want 7fffff 123456 1", q, r, dz);
        end
        do_op(23'd9, 23'd3, -10, -10, fc, fn, bt, q, r, dz, sn);
        checks++;
        if (q !== 23'd3 || r !== 23'd0 || dz !== 1'b0 || fc !== W + 2) begin
            errors++;
            $display("FAIL dz_recover got q=%0d r=%0d dz=%b cyc=%0d want 3 0 0 %0d",
                     q, r, dz, fc, W + 2);
        end
    endtask

    task automatic test_start_while_busy;
        int fc, fn;
        logic [63:0] bt;
        logic [W-1:0] q, r;
        logic dz;
        logic [2*W+2:0] sn;
        do_op(23'd100, 23'd7, 10, -10, fc, fn, bt, q, r, dz, sn);
        checks++;
        if (fc !== W + 2 || fn !== 1 || q !== 23'd14 || r !== 23'd2) begin
            errors++;
            $display("FAIL busy_ignore got cyc=%0d cnt=%0d q=%0d r=%0d want %0d 1 14 2",
                     fc, fn, q, r, W + 2);
        end
    endtask

    task automatic test_reset_midop;
        int fc, fn;
        logic [63:0] bt;
        logic [W-1:0] q, r;
        logic dz;
        logic [2*W+2:0] sn;
        do_op(23'd100, 23'd7, -10, 12, fc, fn, bt, q, r, dz, sn);
        checks++;
        if (sn !== '0) begin
            errors++;
            $display("FAIL midop_reset_outputs got %h want 0", sn);
        end
        checks++;
        if (fn !== 0) begin
            errors++;
            $display("FAIL midop_reset_finish got cnt=%0d want 0", fn);
        end
        do_op(23'd50, 23'd5, -10, -10, fc, fn, bt, q, r, dz, sn);
        checks++;
        if (fc !== W + 2 || q !== 23'd10 || r !== 23'd0 || dz !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got cyc=%0d q=%0d r=%0d dz=%b want %0d 10 0 0",
                     fc, q, r, dz, W + 2);
        end
    endtask

    task automatic test_reset_vs_start;
        @(negedge clk);
        a     = 23'd3;
        b     = 23'd1;
        start = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || finish !== 1'b0) begin
                errors++;
                $display("FAIL reset_beats_start got busy=%b fin=%b want 0 0", busy, finish);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic [W-1:0] ea, eb;
        int last_fin;
        int wait_n;
        longint lhs;
        last_fin = -1;
        @(negedge clk);
        ea = W'($urandom);
        eb = W'($urandom_range(1, 15));
        qa.push_back(ea);
        qb.push_back(eb);
        a     = ea;
        b     = eb;
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wait_n = 0;
            do begin
                @(posedge clk);
                #1;
                wait_n++;
            end while (finish !== 1'b1 && wait_n < 100);
            if (finish !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL b2b_timeout op=%0d no finish within %0d cycles", i, wait_n);
                break;
            end
            if (last_fin >= 0) begin
                checks++;
                if (cyc - last_fin !== W + 3) begin
                    errors++;
                    $display("FAIL b2b_spacing op=%0d got %0d want %0d",
                             i, cyc - last_fin, W + 3);
                end
            end
            last_fin = cyc;
            ea = qa.pop_front();
            eb = qb.pop_front();
            lhs = longint'(quotient) * longint'(eb) + longint'(remainder);
            checks++;
            if (quotient !== ea / eb || remainder !== ea % eb ||
                lhs != longint'(ea) || remainder >= eb || div_zero !== 1'b0) begin
                errors++;
                $display("FAIL b2b_result op=%0d a=%h b=%h got q=%h r=%h want q=%h r=%h",
                         i, ea, eb, quotient, remainder, ea / eb, ea % eb);
            end
            if (i < 999) begin
                ea = W'($urandom);
                if ($urandom_range(0, 3) == 0)
                    eb = W'($urandom_range(1, 15));
                else
                    eb = W'($urandom_range(1, (1 << W) - 1));
                qa.push_back(ea);
                qb.push_back(eb);
                a = ea;
                b = eb;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_start_while_busy();
        test_reset_midop();
        test_reset_vs_start();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
